ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset)
//  to the keyboard on PS2_CLK/PS2_DAT. Open-drain control; the top level ties each *_oe to a pad.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_line_filter.sv | 38 +++
 rtl/ps2_host_tx.sv | 196 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM encoding, error codes and common command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_BITS,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_FAIL
    } tx_state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESEND   = 8'hFE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    // Host-to-device frame after the start bit, sent LSB first: data, odd parity, stop.
    function automatic logic [9:0] tx_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises one raw PS/2 pad, debounces it over FILTER_LEN equal samples and strobes falls.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic fall
);
    localparam int unsigned RUN_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       sync;
    logic [RUN_W-1:0] run;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= '1;
            level <= 1'b1;
            run   <= '0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            fall <= 1'b0;
            if (sync[1] == level) begin
                run <= '0;
            end else if (run == RUN_W'(FILTER_LEN - 1)) begin
                // Level flips on the FILTER_LEN-th consecutive differing sample.
                level <= sync[1];
                run   <= '0;
                fall  <= level;
            end else begin
                run <= run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain pad enables.
// Optional PS2_TX_RETRY_EN: retry a NACK/timeout up to twice before reporting the failure.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = 2500,
    parameter int unsigned TIMEOUT_CYC = 375000,
    parameter int unsigned FILTER_LEN  = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    localparam int unsigned CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic clk_lvl, clk_fall, dat_lvl, dat_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (ps2_clk_i),
        .level   (clk_lvl),
        .fall    (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (ps2_dat_i),
        .level   (dat_lvl),
        .fall    (dat_fall_unused)
    );

    tx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       bitcnt, bitcnt_n;
    logic [9:0]       shift, shift_n;
    logic [7:0]       data, data_n;
    logic             dat_low, dat_low_n;
    logic [1:0]       err_q, err_n;
    logic             fail_now;
    logic [1:0]       fail_code;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]       tries, tries_n;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bitcnt  <= '0;
            shift   <= '1;
            data    <= '0;
            dat_low <= 1'b0;
            err_q   <= ERR_OK;
`ifdef PS2_TX_RETRY_EN
            tries   <= '0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bitcnt  <= bitcnt_n;
            shift   <= shift_n;
            data    <= data_n;
            dat_low <= dat_low_n;
            err_q   <= err_n;
`ifdef PS2_TX_RETRY_EN
            tries   <= tries_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bitcnt_n  = bitcnt;
        shift_n   = shift;
        data_n    = data;
        dat_low_n = dat_low;
        err_n     = err_q;
        fail_now  = 1'b0;
        fail_code = ERR_OK;
`ifdef PS2_TX_RETRY_EN
        tries_n   = tries;
`endif
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (tx_valid) begin
                    data_n    = tx_data;
                    err_n     = ERR_OK;
                    dat_low_n = 1'b0;
                    state_n   = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    tries_n   = '0;
`endif
                end
            end
            ST_INHIBIT: begin
                if (cnt == INHIBIT_LAST) begin
                    state_n   = ST_BITS;
                    cnt_n     = '0;
                    bitcnt_n  = '0;
                    shift_n   = tx_frame(data);
                    dat_low_n = 1'b1;
                end
            end
            ST_BITS: begin
                if (clk_fall) begin
                    cnt_n     = '0;
                    dat_low_n = ~shift[0];
                    shift_n   = {1'b1, shift[9:1]};
                    bitcnt_n  = bitcnt + 4'd1;
                    if (bitcnt == 4'd9) state_n = ST_ACK;
                end else if (cnt == TIMEOUT_LAST) begin
                    fail_now  = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    cnt_n = '0;
                    if (!dat_lvl) begin
                        state_n = ST_WAIT_IDLE;
                    end else begin
                        fail_now  = 1'b1;
                        fail_code = ERR_NACK;
                    end
                end else if (cnt == TIMEOUT_LAST) begin
                    fail_now  = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_lvl && dat_lvl) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (clk_fall) begin
                    cnt_n = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    fail_now  = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            ST_FAIL: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase

        if (fail_now) begin
            cnt_n     = '0;
            dat_low_n = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (tries != 2'd2) begin
                tries_n = tries + 2'd1;
                state_n = ST_INHIBIT;
            end else begin
                state_n = ST_FAIL;
                err_n   = fail_code;
            end
`else
            state_n = ST_FAIL;
            err_n   = fail_code;
`endif
        end
    end

    assign tx_ready   = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_WAIT_IDLE) && clk_lvl && dat_lvl;
    assign error      = (state == ST_FAIL);
    assign err_code   = err_q;
    assign ps2_clk_oe = (state == ST_INHIBIT);
    // Start bit is asserted in the last inhibit cycle and held until the first device fall.
    assign ps2_dat_oe = ((state == ST_INHIBIT) && (cnt == INHIBIT_LAST)) ||
                        (((state == ST_BITS) || (state == ST_ACK)) && dat_low);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx against a PS/2 device model on an open-drain bus.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH   = 40;
    localparam int TOUT  = 3000;
    localparam int FLEN  = 4;
    localparam int HALF  = 20;
    localparam int BOUND = 20000;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, error;
    logic [1:0] err_code;
    logic       ps2_clk_i, ps2_dat_i, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TOUT), .FILTER_LEN(FLEN)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #20 clock = ~clock;

    int         vectors = 0;
    int         miscompares = 0;
    int         exp_outcome = 0;      // 0 no pulse allowed, 1 done expected, 2 error expected
    logic [1:0] exp_code = ERR_OK;
    int         done_seen = 0, err_seen = 0;
    int         inhibit_phases = 0, inh_run = 0, last_inh = 0;
    logic [9:0] last_bits = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Expected frame from the byte: data LSB first, then odd parity, then stop.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    always @(negedge clock) begin
        if (ps2_clk_oe) inh_run++;
        else if (inh_run != 0) begin
            last_inh = inh_run;
            inh_run  = 0;
            inhibit_phases++;
        end
        if (reset_n) begin
            check("busy_vs_ready", busy, !tx_ready);
            check("done_error_excl", done & error, 0);
            if (tx_ready) check("idle_lines", {ps2_clk_oe, ps2_dat_oe}, 0);
            if (done) begin
                done_seen++;
                check("done_expected", exp_outcome, 1);
                check("done_code", err_code, ERR_OK);
            end
            if (error) begin
                err_seen++;
                check("error_expected", exp_outcome, 2);
                check("error_code", err_code, exp_code);
                check("error_lines", {ps2_clk_oe, ps2_dat_oe}, 0);
            end
        end
    end

    task automatic request(input logic [7:0] b);
        int n = 0;
        @(negedge clock);
        while (tx_ready !== 1'b1 && n < BOUND) begin @(negedge clock); n++; end
        check("ready_before_req", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        tx_data  = '0;
    endtask

    // Wait for an inhibit/release, check the start bit, then clock the frame (mode 0 ACK, 1 NACK, 2 silent).
    task automatic wait_release();
        int n = 0;
        while (ps2_clk_i !== 1'b0 && n < BOUND) begin @(negedge clock); n++; end
        check("inhibit_seen", ps2_clk_i, 0);
        n = 0;
        while (ps2_clk_i !== 1'b1 && n < BOUND) begin @(negedge clock); n++; end
        check("clk_released", ps2_clk_i, 1);
        check("start_bit", ps2_dat_i, 0);
    endtask

    task automatic device_frame(input int mode, output logic [9:0] bits);
        bits = '1;
        wait_release();
        if (mode != 2) begin
            for (int k = 1; k <= 10; k++) begin
                repeat (HALF) @(negedge clock);
                dev_clk = 1'b0;
                repeat (HALF) @(negedge clock);
                bits[k-1] = ps2_dat_i;
                dev_clk = 1'b1;
            end
            repeat (HALF / 2) @(negedge clock);
            dev_dat = (mode == 1);
            repeat (HALF / 2) @(negedge clock);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            dev_clk = 1'b1;
            repeat (HALF / 2) @(negedge clock);
            dev_dat = 1'b1;
        end
    endtask

    task automatic run_tx(input logic [7:0] b, input int mode, input bit poke);
        logic [9:0] bits, exp;
        int d0, e0, p0, n, att;
        att         = (mode == 0) ? 1 : ATTEMPTS;
        exp_outcome = (mode == 0) ? 1 : 2;
        exp_code    = (mode == 1) ? ERR_NACK : ERR_TIMEOUT;
        d0 = done_seen; e0 = err_seen; p0 = inhibit_phases;
        request(b);
        if (poke) begin
            repeat (5) @(negedge clock);
            check("busy_at_poke", busy, 1);
            tx_data  = CMD_RESET;
            tx_valid = 1'b1;
            @(negedge clock);
            tx_valid = 1'b0;
        end
        for (int a = 0; a < att; a++) device_frame(mode, bits);
        last_bits = bits;
        if (mode != 2) begin
            exp = model_frame(b);
            for (int i = 0; i < 10; i++) check($sformatf("frame_bit%0d", i), bits[i], exp[i]);
        end
        n = 0;
        while (done_seen == d0 && err_seen == e0 && n < BOUND) begin @(negedge clock); n++; end
        check("done_count", done_seen - d0, (mode == 0) ? 1 : 0);
        check("error_count", err_seen - e0, (mode == 0) ? 0 : 1);
        check("attempts", inhibit_phases - p0, att);
        check("inhibit_len", last_inh >= INH, 1);
        n = 0;
        while (tx_ready !== 1'b1 && n < BOUND) begin @(negedge clock); n++; end
        check("ready_after", tx_ready, 1);
        check("err_code_held", err_code, (mode == 0) ? ERR_OK : exp_code);
        check("lines_released", {ps2_clk_oe, ps2_dat_oe}, 0);
        if (poke) begin
            repeat (3 * INH) @(negedge clock);
            check("poke_ignored", inhibit_phases - p0, att);
        end
        exp_outcome = 0;
    endtask

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end

    initial begin
        logic [9:0] bits;
        int         d0, e0, p0, n;
        repeat (4) @(negedge clock);
        check("reset_state", {tx_ready, busy, done, error, err_code, ps2_clk_oe, ps2_dat_oe}, 8'b1000_0000);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);

        run_tx(CMD_SET_LEDS, 0, 1'b0);
        check("ed_data_lit", last_bits[7:0], 8'hED);
        check("ed_parity_lit", last_bits[8], 1);
        check("ed_stop_lit", last_bits[9], 1);

        run_tx(CMD_ENABLE, 0, 1'b1);
        check("f4_data_lit", last_bits[7:0], 8'hF4);
        check("f4_parity_lit", last_bits[8], 0);

        run_tx(8'h00, 0, 1'b0);
        check("zero_parity_lit", last_bits[8], 1);

        run_tx(CMD_RESET, 1, 1'b0);
        run_tx(CMD_RESEND, 2, 1'b0);

`ifdef PS2_TX_RETRY_EN
        exp_outcome = 1;
        d0 = done_seen; e0 = err_seen; p0 = inhibit_phases;
        request(CMD_SET_LEDS);
        device_frame(1, bits);
        device_frame(0, bits);
        n = 0;
        while (done_seen == d0 && err_seen == e0 && n < BOUND) begin @(negedge clock); n++; end
        repeat (5) @(negedge clock);
        check("retry_done", done_seen - d0, 1);
        check("retry_no_error", err_seen - e0, 0);
        check("retry_inhibits", inhibit_phases - p0, 2);
        check("retry_data", bits[7:0], 8'hED);
        exp_outcome = 0;
`endif

        request(CMD_SET_LEDS);
        wait_release();
        for (int k = 1; k <= 5; k++) begin
            repeat (HALF) @(negedge clock);
            dev_clk = 1'b0;
            if (k < 5) begin
                repeat (HALF) @(negedge clock);
                dev_clk = 1'b1;
            end
        end
        repeat (HALF / 2) @(negedge clock);
        check("pre_reset_dat_oe", ps2_dat_oe, 1);
        #7 reset_n = 1'b0;
        #1;
        check("reset_mid_lines", {ps2_clk_oe, ps2_dat_oe}, 0);
        check("reset_mid_ready", tx_ready, 1);
        dev_clk = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3 * FLEN + 10) @(negedge clock);
        check("post_reset_state", {tx_ready, busy, done, error, err_code, ps2_clk_oe, ps2_dat_oe}, 8'b1000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
